cache_mem_arbiter: RTL and testbench

- Sits directly downstream of the instruction-cache and data-cache controllers.
- Multiplexes their line-sized physical-memory requests onto the single physical-memory port.
- Each cache controller holds its pmem_read/pmem_write high until it sees its pmem_resp. The arbiter grants one client at a time, holds that grant until memory responds, then inserts one cooldown cycle so the served controller can drop its request.
- Round-robin between clients when both are pending.

---
 rtl/cache_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Arbiter between icache and dcache line requests and the single pmem port.
// One client is served at a time, round-robin on ties, with a cooldown cycle after each response.
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    COOLDOWN
  } state_t;

  state_t                  state;
  state_t                  state_nx;
  logic                    last_d;
  logic                    last_d_nx;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   addr_nx;
  logic [LINE_WIDTH-1:0]   wdata_q;
  logic [LINE_WIDTH-1:0]   wdata_nx;
  logic                    wr_q;
  logic                    wr_nx;
  logic                    i_req;
  logic                    d_req;
  logic                    win_i;
  logic                    win_d;
  logic                    granted;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  // last_d set means the dcache was served last, so icache wins a tie
  assign win_i = i_req & (~d_req | last_d);
  assign win_d = d_req & ~win_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last_d  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state   <= state_nx;
      last_d  <= last_d_nx;
      addr_q  <= addr_nx;
      wdata_q <= wdata_nx;
      wr_q    <= wr_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    last_d_nx   = last_d;
    addr_nx     = addr_q;
    wdata_nx    = wdata_q;
    wr_nx       = wr_q;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          win_i: begin
            state_nx  = GRANT_I;
            last_d_nx = 1'b0;
            addr_nx   = i_pmem_address;
            wr_nx     = 1'b0;
          end
          win_d: begin
            state_nx  = GRANT_D;
            last_d_nx = 1'b1;
            addr_nx   = d_pmem_address;
            wdata_nx  = d_pmem_wdata;
            wr_nx     = d_pmem_write;
          end
          default: ;
        endcase
      end
      GRANT_I: begin
        if (mem_resp) begin
          i_pmem_resp = 1'b1;
          state_nx    = COOLDOWN;
        end
      end
      GRANT_D: begin
        if (mem_resp) begin
          d_pmem_resp = 1'b1;
          state_nx    = COOLDOWN;
        end
      end
      COOLDOWN: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  assign granted      = (state == GRANT_I) | (state == GRANT_D);
  assign mem_read     = granted & ~wr_q;
  assign mem_write    = granted & wr_q;
  assign mem_address  = addr_q;
  assign mem_wdata    = wdata_q;
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: behavioural clients and memory,
// a cycle-stamped reference model, and a separate negedge monitor.
module tb_cache_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          i_pmem_read = 1'b0;
  logic [AW-1:0] i_pmem_address = '0;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read = 1'b0;
  logic          d_pmem_write = 1'b0;
  logic [AW-1:0] d_pmem_address = '0;
  logic [LW-1:0] d_pmem_wdata = '0;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata = '0;
  logic          mem_resp = 1'b0;

  cache_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  typedef struct {
    bit            d;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    int            start;
  } txn_t;

  typedef struct {
    bit            d;
    logic [LW-1:0] rdata;
    int            cyc;
  } rsp_t;

  txn_t txn_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  bit            c_req[2];
  bit            c_served[2];
  int            c_gap[2];
  logic [AW-1:0] c_addr[2];
  logic [LW-1:0] c_wdata;
  bit            c_rd;
  bit            c_wr;

  bit            gen_en = 0;
  int            p_req = 0;
  int            gap_max = 0;
  bit            perturb_en = 0;
  int            fix_lat = -1;
  bit            fix_rd_en = 0;
  logic [LW-1:0] fix_rdata = '0;

  bit   m_act = 0;
  txn_t m_cur;
  int   free_at = 0;
  bit   last_d = 1;
  bit   mbusy = 0;
  int   lat = 0;

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    logic [1:0] op;
    bit         ir;
    bit         dr;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (c_served[k]) begin
        c_req[k] = 0;
        c_served[k] = 0;
        c_gap[k] = int'($urandom_range(gap_max, 0));
      end else if (!c_req[k] && gen_en) begin
        if (c_gap[k] > 0) c_gap[k]--;
        else if (int'($urandom_range(99, 0)) < p_req) begin
          c_req[k] = 1;
          c_addr[k] = $urandom;
          if (k == 1) begin
            op = 2'($urandom_range(3, 1));
            c_rd = op[0];
            c_wr = op[1];
            c_wdata = rnd_line();
          end
        end
      end else if (c_req[k] && perturb_en && m_act && (m_cur.d == (k == 1))
                   && $urandom_range(3, 0) == 0) begin
        c_addr[k] = $urandom;
        if (k == 1) c_wdata = rnd_line();
      end
    end
    i_pmem_read    = c_req[0];
    i_pmem_address = c_addr[0];
    d_pmem_read    = c_req[1] & c_rd;
    d_pmem_write   = c_req[1] & c_wr;
    d_pmem_address = c_addr[1];
    d_pmem_wdata   = c_wdata;
    mem_resp  = 1'b0;
    mem_rdata = rnd_line();
    if (mem_read || mem_write) begin
      if (!mbusy) begin
        mbusy = 1;
        lat = (fix_lat >= 0) ? fix_lat : int'($urandom_range(3, 0));
      end
      if (lat == 0) begin
        mem_resp = 1'b1;
        mbusy = 0;
        if (fix_rd_en) mem_rdata = fix_rdata;
      end else lat--;
    end else begin
      mbusy = 0;
      if ($urandom_range(9, 0) == 0) mem_resp = 1'b1;
    end
    ir = c_req[0];
    dr = c_req[1];
    if (m_act && mem_resp) begin
      rsp_q.push_back('{m_cur.d, mem_rdata, cyc});
      c_served[m_cur.d] = 1;
      m_act = 0;
      free_at = cyc + 2;
    end else if (!m_act && cyc >= free_at && (ir || dr)) begin
      m_cur.d = dr && (!ir || !last_d);
      m_cur.wr = m_cur.d && c_wr;
      m_cur.addr = c_addr[m_cur.d];
      m_cur.wdata = c_wdata;
      m_cur.start = cyc + 1;
      last_d = m_cur.d;
      m_act = 1;
      txn_q.push_back(m_cur);
    end
  endtask

  task automatic drain(int max);
    int n = 0;
    do begin
      step();
      n++;
    end while ((m_act || c_req[0] || c_req[1] || c_served[0] || c_served[1]
                || cyc < free_at) && n < max);
    if (n >= max) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout cyc=%0d: still busy after %0d cycles", cyc, n);
    end
  endtask

  initial begin : monitor
    txn_t cur;
    rsp_t r;
    bit   cur_act = 0;
    bit   ei;
    bit   ed;
    forever begin
      @(negedge clk);
      if (!rst_n) cur_act = 0;
      else begin
        chk("rw_exclusive", LW'(mem_read & mem_write), '0);
        chk("resp_exclusive", LW'(i_pmem_resp & d_pmem_resp), '0);
        chk("i_rdata_wire", i_pmem_rdata, mem_rdata);
        chk("d_rdata_wire", d_pmem_rdata, mem_rdata);
        if (txn_q.size() > 0 && txn_q[0].start == cyc) begin
          cur = txn_q.pop_front();
          cur_act = 1;
        end
        chk("mem_read", LW'(mem_read), LW'(cur_act & !cur.wr));
        chk("mem_write", LW'(mem_write), LW'(cur_act & cur.wr));
        if (cur_act) chk("mem_address", LW'(mem_address), LW'(cur.addr));
        if (cur_act && cur.wr) chk("mem_wdata", mem_wdata, cur.wdata);
        ei = 0;
        ed = 0;
        if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
          r = rsp_q.pop_front();
          ei = !r.d;
          ed = r.d;
          chk(r.d ? "d_rdata" : "i_rdata", r.d ? d_pmem_rdata : i_pmem_rdata, r.rdata);
          cur_act = 0;
        end
        chk("i_pmem_resp", LW'(i_pmem_resp), LW'(ei));
        chk("d_pmem_resp", LW'(d_pmem_resp), LW'(ed));
      end
    end
  end

  task automatic check_idle_port(string tag);
    chk({tag, "_mem_read"}, LW'(mem_read), '0);
    chk({tag, "_mem_write"}, LW'(mem_write), '0);
    chk({tag, "_i_resp"}, LW'(i_pmem_resp), '0);
    chk({tag, "_d_resp"}, LW'(d_pmem_resp), '0);
  endtask

  initial begin : stim
    int n;
    c_req = '{0, 0};
    c_served = '{0, 0};
    c_gap = '{0, 0};
    c_addr = '{'0, '0};
    c_wdata = '0;
    c_rd = 0;
    c_wr = 0;
    repeat (3) @(posedge clk);
    #2;
    check_idle_port("reset");
    chk("reset_mem_address", LW'(mem_address), '0);
    chk("reset_mem_wdata", mem_wdata, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    free_at = cyc + 1;

    fix_lat = 3;
    fix_rd_en = 1;
    fix_rdata = {8{32'hAAAA_AAAA}};
    c_req[0] = 1;
    c_addr[0] = 32'h0000_1000;
    drain(50);

    c_req[1] = 1;
    c_rd = 0;
    c_wr = 1;
    c_addr[1] = 32'h0000_2000;
    c_wdata = {8{32'h5555_5555}};
    step();
    step();
    c_addr[1] = 32'h0000_3000;
    drain(50);

    fix_rd_en = 0;
    c_req[0] = 1;
    c_addr[0] = 32'h0000_4000;
    c_req[1] = 1;
    c_rd = 1;
    c_wr = 0;
    c_addr[1] = 32'h0000_5000;
    drain(50);

    fix_lat = 1;
    gen_en = 1;
    p_req = 100;
    gap_max = 0;
    repeat (40) step();
    gen_en = 0;
    drain(50);

    fix_lat = -1;
    p_req = 30;
    gap_max = 3;
    perturb_en = 1;
    gen_en = 1;
    repeat (3000) step();
    gen_en = 0;
    perturb_en = 0;
    drain(100);

    fix_lat = 3;
    c_req[0] = 1;
    c_addr[0] = $urandom;
    n = 0;
    do begin
      step();
      n++;
    end while (!(m_act && !m_cur.d) && n < 50);
    mem_resp = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle_port("midreset");
    txn_q.delete();
    rsp_q.delete();
    m_act = 0;
    last_d = 1;
    mbusy = 0;
    c_req = '{0, 0};
    c_served = '{0, 0};
    i_pmem_read = 1'b0;
    d_pmem_read = 1'b0;
    d_pmem_write = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    free_at = cyc + 1;

    fix_lat = -1;
    c_req[0] = 1;
    c_addr[0] = $urandom;
    c_req[1] = 1;
    c_rd = 0;
    c_wr = 1;
    c_addr[1] = $urandom;
    c_wdata = rnd_line();
    drain(50);
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
